serial_pack_ctrl: RTL and testbench
===================================

Name: serial_pack_ctrl

Overview:
Command controller between the UART receiver and the multi-channel diff_freq_serial_out datapath. It assembles PACK_NUM-byte packets from received UART bytes and decodes the control byte. It then issues per-channel load/start/stop strobes with the 32-bit output and frequency patterns, and returns one ACK/NAK byte per packet through the UART transmitter. It also tracks channel run state and recovers from truncated packets via an inter-byte timeout.

Parameters:
DATA_BIT, 32, width of the output pattern and the frequency pattern
PACK_NUM, (DATA_BIT/8)*2+1, bytes per packet (9 at default)
CH_NUM, 16, number of serial output channels (max 16)
TIMEOUT_CYC, 200000, idle cycles allowed between bytes inside a packet (2 ms at 100 MHz)
ACK_BYTE, 8'h06, reply for an accepted packet
NAK_BYTE, 8'h15, reply for a rejected packet

Ports:
clk  input  1  system clock (PLL output, 100 MHz)
rst_n  input  1  asynchronous active-low reset
i_data  input  8  received UART byte
i_rx_done_tick  input  1  one-cycle strobe: i_data valid
i_done_tick  input  CH_NUM  per-channel pattern-complete strobe from datapath
i_tx_done_tick  input  1  UART transmitter finished a byte
o_output_pattern  output  DATA_BIT  output pattern for addressed channel
o_freq_pattern  output  DATA_BIT  frequency pattern for addressed channel
o_load_tick  output  CH_NUM  one-hot one-cycle pattern load strobe
o_start_tick  output  CH_NUM  one-hot one-cycle start strobe
o_stop_tick  output  CH_NUM  one-hot one-cycle stop strobe
o_run  output  CH_NUM  channel running flags
o_tx_start  output  1  one-cycle request to transmit o_tx_data
o_tx_data  output  8  reply byte
o_busy  output  1  high in any state other than IDLE/RECV
o_err_tick  output  1  one-cycle strobe: timeout or dropped byte

Behaviour:
- Reset: all outputs 0, byte counter 0, timeout counter 0, state IDLE. Asserting reset mid-packet or mid-reply discards everything; no reply is sent.
- Packet byte order: bytes 0-3 output pattern LSB first; bytes 4-7 frequency pattern LSB first; byte 8 control.
- Control byte: [7:6] cmd (00 LOAD, 01 LOAD_START, 10 STOP, 11 reserved); [5:4] ignored; [3:0] channel.
- IDLE: a byte tick stores byte 0, count=1, and goes to RECV.
- RECV: each byte tick shifts in and increments count. The timeout counter clears on each tick. If it reaches TIMEOUT_CYC-1 with no byte, the partial packet is discarded, o_err_tick pulses, and the FSM returns to IDLE with no reply. A tick when count==PACK_NUM-1 stores the control byte and goes to DECODE.
- DECODE (1 cycle): the packet is rejected (NAK) if any of these holds:
  - cmd==11;
  - channel>=CH_NUM;
  - cmd is LOAD or LOAD_START and o_run[ch]==1.
  Otherwise it is accepted (ACK). Go to ISSUE.
- ISSUE (1 cycle): if accepted, pattern outputs are driven and held until the next ISSUE.
  - LOAD: o_load_tick[ch]=1.
  - LOAD_START: o_load_tick[ch] and o_start_tick[ch] both pulse this cycle; o_run[ch] sets next cycle.
  - STOP: o_stop_tick[ch]=1; o_run[ch] clears next cycle. STOP on an idle channel is accepted as a no-op strobe.
  - If rejected: no strobes.
  - Go to REPLY.
- Latency: control byte tick at cycle N -> DECODE at N+1 -> strobes at N+2 -> o_tx_start at N+3.
- REPLY (1 cycle): o_tx_start=1, o_tx_data=ACK_BYTE/NAK_BYTE, then go to WAIT_TX.
- WAIT_TX: hold o_tx_data; i_tx_done_tick returns the FSM to IDLE.
- In DECODE/ISSUE/REPLY/WAIT_TX: byte ticks are dropped with o_err_tick.
- o_run: i_done_tick[k] clears o_run[k] in any state. If set and clear hit the same bit in the same cycle, set wins. i_done_tick on a non-running channel is ignored.
- Counters are sized by $clog2; the timeout counter saturates.

Decomposition:
- Shared package serial_pack_pkg:
  - cmd encodings (CMD_LOAD, CMD_LOAD_START, CMD_STOP);
  - control-byte field positions;
  - ACK/NAK defaults;
  - FSM state enum.
- One sub-module: pack_timeout_timer (load/clear, saturating count, expire strobe).

Test Plan:
- LOAD_START ch3: bytes 78 56 34 12 EF CD AB 89 43 -> o_output_pattern=32'h12345678, o_freq_pattern=32'h89ABCDEF; o_load_tick=o_start_tick=16'h0008 two cycles after last tick; o_run[3]=1; o_tx_data=8'h06.
- While ch3 running, LOAD ch3 (control 8'h03) -> no strobes, o_tx_data=8'h15, pattern outputs unchanged; then STOP (8'h83) -> o_stop_tick=16'h0008, o_run[3]=0, ACK.
- Send 5 bytes, then idle 200000 cycles -> o_err_tick once, no reply. Next full packet with control 8'h01 is decoded correctly (ch1 load, ACK).
- Reserved cmd 8'hC0 and channel out of range with CH_NUM=8 (control 8'h4A) -> NAK each, no strobes.
- i_done_tick[3] on the same cycle as LOAD_START ch3 set -> o_run[3]=1. i_done_tick[3] alone later -> o_run[3]=0.
- Byte arrives during WAIT_TX -> o_err_tick, byte ignored. Assert rst_n low mid-packet (byte 4) -> all outputs 0, no o_tx_start, next packet accepted.

Source files
------------

// File: rtl/serial_pack_pkg.sv
// Shared definitions for the UART packet command controller: command codes,
// control-byte field positions, reply bytes and controller states.
package serial_pack_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD       = 2'b00,
    CMD_LOAD_START = 2'b01,
    CMD_STOP       = 2'b10,
    CMD_RSVD       = 2'b11
  } cmd_e;

  // Control byte: [7:6] command, [5:4] don't care, [3:0] channel
  localparam int unsigned CTRL_CMD_LSB = 6;
  localparam int unsigned CTRL_CMD_W   = 2;
  localparam int unsigned CTRL_CH_W    = 4;

  localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECV    = 3'd1,
    ST_DECODE  = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_REPLY   = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

endpackage

// File: rtl/pack_timeout_timer.sv
// Inter-byte idle timer: cleared by each received byte (or while not receiving),
// otherwise counts up and saturates; flags expiry on the last allowed idle cycle.
module pack_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic expire_c_o
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_c_o = !clear_i && (count_q == LAST);

endmodule

// File: rtl/serial_pack_ctrl.sv
// Assembles UART bytes into pattern/frequency/control packets, issues per-channel
// load/start/stop strobes, tracks channel run flags and replies ACK/NAK per packet.
module serial_pack_ctrl
  import serial_pack_pkg::*;
#(
  parameter int unsigned DATA_BIT    = 32,
  parameter int unsigned PACK_NUM    = (DATA_BIT / 8) * 2 + 1,
  parameter int unsigned CH_NUM      = 16,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter logic [7:0]  ACK_BYTE    = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE    = NAK_BYTE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          i_data,
  input  logic                i_rx_done_tick,
  input  logic [CH_NUM-1:0]   i_done_tick,
  input  logic                i_tx_done_tick,
  output logic [DATA_BIT-1:0] o_output_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic [CH_NUM-1:0]   o_load_tick,
  output logic [CH_NUM-1:0]   o_start_tick,
  output logic [CH_NUM-1:0]   o_stop_tick,
  output logic [CH_NUM-1:0]   o_run,
  output logic                o_tx_start,
  output logic [7:0]          o_tx_data,
  output logic                o_busy,
  output logic                o_err_tick
);

  localparam int unsigned SH_W  = 2 * DATA_BIT;
  localparam int unsigned CNT_W = $clog2(PACK_NUM);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SH_W-1:0]        sh_q, sh_d;
  cmd_e                   cmd_q, cmd_d;
  logic [CTRL_CH_W-1:0]   ch_q, ch_d;
  logic                   accept_q, accept_d;
  logic [DATA_BIT-1:0]    pat_q, pat_d, freq_q, freq_d;
  logic [CH_NUM-1:0]      load_q, load_d, start_q, start_d, stop_q, stop_d;
  logic [CH_NUM-1:0]      run_q, run_d;
  logic                   tx_start_q, tx_start_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic                   tmr_clear_c;
  logic                   tmr_expire_c;
  logic [CH_NUM-1:0]      ch_oh_c;
  logic                   accept_c;

  assign tmr_clear_c = (state_q != ST_RECV) || i_rx_done_tick;

  pack_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (tmr_clear_c),
    .expire_c_o (tmr_expire_c)
  );

  // Out-of-range channels shift the one-hot fully out, giving an all-zero mask
  assign ch_oh_c  = CH_NUM'(1) << ch_q;
  assign accept_c = (cmd_q != CMD_RSVD) && (32'(ch_q) < CH_NUM) &&
                    !((cmd_q != CMD_STOP) && |(run_q & ch_oh_c));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    cmd_d      = cmd_q;
    ch_d       = ch_q;
    accept_d   = accept_q;
    pat_d      = pat_q;
    freq_d     = freq_q;
    load_d     = '0;
    start_d    = '0;
    stop_d     = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    err_d      = 1'b0;
    // Done clears a running flag, but a start strobe in the same cycle wins
    run_d      = (run_q & ~i_done_tick & ~stop_q) | start_q;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_done_tick) begin
          sh_d    = {i_data, sh_q[SH_W-1:8]};
          cnt_d   = CNT_W'(1);
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (i_rx_done_tick) begin
          if (cnt_q == CNT_W'(PACK_NUM - 1)) begin
            cmd_d   = cmd_e'(i_data[CTRL_CMD_LSB +: CTRL_CMD_W]);
            ch_d    = i_data[CTRL_CH_W-1:0];
            cnt_d   = '0;
            state_d = ST_DECODE;
          end else begin
            sh_d  = {i_data, sh_q[SH_W-1:8]};
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (tmr_expire_c) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        accept_d = accept_c;
        if (accept_c) begin
          pat_d   = sh_q[DATA_BIT-1:0];
          freq_d  = sh_q[SH_W-1:DATA_BIT];
          load_d  = (cmd_q != CMD_STOP) ? ch_oh_c : '0;
          start_d = (cmd_q == CMD_LOAD_START) ? ch_oh_c : '0;
          stop_d  = (cmd_q == CMD_STOP) ? ch_oh_c : '0;
        end
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        tx_start_d = 1'b1;
        tx_data_d  = accept_q ? ACK_BYTE : NAK_BYTE;
        state_d    = ST_REPLY;
      end
      ST_REPLY: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bytes arriving while a packet is being processed are dropped
    if (i_rx_done_tick && (state_q inside {ST_DECODE, ST_ISSUE, ST_REPLY, ST_WAIT_TX})) begin
      err_d = 1'b1;
    end

    busy_d = !(state_d inside {ST_IDLE, ST_RECV});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      cmd_q      <= CMD_LOAD;
      ch_q       <= '0;
      accept_q   <= 1'b0;
      pat_q      <= '0;
      freq_q     <= '0;
      load_q     <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      run_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      cmd_q      <= cmd_d;
      ch_q       <= ch_d;
      accept_q   <= accept_d;
      pat_q      <= pat_d;
      freq_q     <= freq_d;
      load_q     <= load_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      run_q      <= run_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign o_output_pattern = pat_q;
  assign o_freq_pattern   = freq_q;
  assign o_load_tick      = load_q;
  assign o_start_tick     = start_q;
  assign o_stop_tick      = stop_q;
  assign o_run            = run_q;
  assign o_tx_start       = tx_start_q;
  assign o_tx_data        = tx_data_q;
  assign o_busy           = busy_q;
  assign o_err_tick       = err_q;

endmodule

// File: tb/tb_serial_pack_ctrl.sv
// Bench for serial_pack_ctrl: directed scenarios plus randomized packets checked
// against a packet-level model of channel run state and replies.
module tb_serial_pack_ctrl;

  localparam int unsigned CH = 8;
  localparam int unsigned TO = 64;
  localparam int unsigned DB = 32;

  logic          clk;
  logic          rst_n;
  logic [7:0]    data;
  logic          rx_tick;
  logic [CH-1:0] done;
  logic          tx_done;
  logic [DB-1:0] o_output_pattern, o_freq_pattern;
  logic [CH-1:0] o_load_tick, o_start_tick, o_stop_tick, o_run;
  logic          o_tx_start, o_busy, o_err_tick;
  logic [7:0]    o_tx_data;

  serial_pack_ctrl #(
    .DATA_BIT    (DB),
    .CH_NUM      (CH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_data           (data),
    .i_rx_done_tick   (rx_tick),
    .i_done_tick      (done),
    .i_tx_done_tick   (tx_done),
    .o_output_pattern (o_output_pattern),
    .o_freq_pattern   (o_freq_pattern),
    .o_load_tick      (o_load_tick),
    .o_start_tick     (o_start_tick),
    .o_stop_tick      (o_stop_tick),
    .o_run            (o_run),
    .o_tx_start       (o_tx_start),
    .o_tx_data        (o_tx_data),
    .o_busy           (o_busy),
    .o_err_tick       (o_err_tick)
  );

  logic [2*DB+4*CH+10:0] all_out;
  assign all_out = {o_output_pattern, o_freq_pattern, o_load_tick, o_start_tick,
                    o_stop_tick, o_run, o_tx_start, o_tx_data, o_busy, o_err_tick};

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [CH-1:0] m_run;
  logic [DB-1:0] m_op, m_fp;
  logic [CH-1:0] exp_load, exp_start, exp_stop;
  logic [7:0]    exp_txd;

  // Observations captured by send_packet
  logic [CH-1:0] obs_load, obs_start, obs_stop, obs_run;
  logic [DB-1:0] obs_op, obs_fp;
  logic          obs_txs, obs_txs2, obs_busy, obs_busy_end, obs_err;
  logic [7:0]    obs_txd, obs_txd2;
  int            obs_gap_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_run = '0;
    m_op  = '0;
    m_fp  = '0;
  endtask

  task automatic model_packet(input logic [31:0] op, input logic [31:0] fp,
                              input logic [7:0] ctl, input logic [CH-1:0] dmask);
    int cmd;
    int ch;
    bit acc;
    cmd = int'(ctl[7:6]);
    ch  = int'(ctl[3:0]);
    acc = (cmd != 3) && (ch < int'(CH));
    if (acc && cmd != 2 && m_run[ch]) acc = 1'b0;
    exp_load  = '0;
    exp_start = '0;
    exp_stop  = '0;
    if (acc) begin
      if (cmd != 2) exp_load[ch] = 1'b1;
      if (cmd == 1) exp_start[ch] = 1'b1;
      if (cmd == 2) exp_stop[ch] = 1'b1;
      m_op = op;
      m_fp = fp;
    end
    exp_txd = acc ? 8'h06 : 8'h15;
    m_run   = (m_run & ~dmask & ~exp_stop) | exp_start;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    data    = b;
    rx_tick = 1'b1;
    @(negedge clk);
    rx_tick = 1'b0;
  endtask

  task automatic send_packet(input logic [31:0] op, input logic [31:0] fp,
                             input logic [7:0] ctl, input logic [CH-1:0] dmask,
                             input bit poke, input int gap);
    obs_gap_err = 0;
    for (int i = 0; i < 8; i++) begin
      drive_byte((i < 4) ? op[8*i +: 8] : fp[8*(i-4) +: 8]);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (o_err_tick) obs_gap_err++;
      end
    end
    drive_byte(ctl);
    obs_busy = o_busy;
    @(negedge clk);
    obs_load  = o_load_tick;
    obs_start = o_start_tick;
    obs_stop  = o_stop_tick;
    obs_op    = o_output_pattern;
    obs_fp    = o_freq_pattern;
    done      = dmask;
    @(negedge clk);
    done    = '0;
    obs_txs = o_tx_start;
    obs_txd = o_tx_data;
    obs_run = o_run;
    @(negedge clk);
    obs_txs2 = o_tx_start;
    obs_txd2 = o_tx_data;
    obs_err  = 1'b0;
    if (poke) begin
      data    = 8'hA5;
      rx_tick = 1'b1;
      @(negedge clk);
      rx_tick = 1'b0;
      obs_err = o_err_tick;
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done      = 1'b0;
    obs_busy_end = o_busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got %h want 0", all_out);
    end
  endtask

  task automatic test_load_start();
    send_packet(32'h12345678, 32'h89ABCDEF, 8'h43, '0, 1'b0, 0);
    model_packet(32'h12345678, 32'h89ABCDEF, 8'h43, '0);
    checks++;
    if (obs_op !== 32'h12345678 || obs_fp !== 32'h89ABCDEF) begin
      errors++;
      $display("FAIL ls_patterns: got %h/%h want 12345678/89abcdef", obs_op, obs_fp);
    end
    checks++;
    if (obs_load !== 8'h08 || obs_start !== 8'h08 || obs_stop !== 8'h00) begin
      errors++;
      $display("FAIL ls_strobes: got l=%h s=%h p=%h want 08/08/00", obs_load, obs_start, obs_stop);
    end
    checks++;
    if (obs_txs !== 1'b1 || obs_txd !== 8'h06) begin
      errors++;
      $display("FAIL ls_reply: got start=%b data=%h want 1/06", obs_txs, obs_txd);
    end
    checks++;
    if (obs_run !== 8'h08) begin
      errors++;
      $display("FAIL ls_run: got %h want 08", obs_run);
    end
    checks++;
    if (obs_busy !== 1'b1 || obs_busy_end !== 1'b0 || obs_txs2 !== 1'b0 || obs_txd2 !== 8'h06) begin
      errors++;
      $display("FAIL ls_handshake: got busy=%b end=%b txs2=%b txd2=%h want 1/0/0/06",
               obs_busy, obs_busy_end, obs_txs2, obs_txd2);
    end
  endtask

  task automatic test_reject_running();
    send_packet(32'hDEADBEEF, 32'hCAFEF00D, 8'h03, '0, 1'b0, 0);
    model_packet(32'hDEADBEEF, 32'hCAFEF00D, 8'h03, '0);
    checks++;
    if ({obs_load, obs_start, obs_stop} !== '0 || obs_txd !== 8'h15) begin
      errors++;
      $display("FAIL busy_load_nak: got strobes=%h data=%h want 0/15",
               {obs_load, obs_start, obs_stop}, obs_txd);
    end
    checks++;
    if (obs_op !== 32'h12345678 || obs_fp !== 32'h89ABCDEF) begin
      errors++;
      $display("FAIL nak_patterns_held: got %h/%h want 12345678/89abcdef", obs_op, obs_fp);
    end
    send_packet(32'h0, 32'h0, 8'h83, '0, 1'b0, 0);
    model_packet(32'h0, 32'h0, 8'h83, '0);
    checks++;
    if (obs_stop !== 8'h08 || obs_load !== 8'h00 || obs_run !== 8'h00 || obs_txd !== 8'h06) begin
      errors++;
      $display("FAIL stop_ch3: got stop=%h load=%h run=%h data=%h want 08/00/00/06",
               obs_stop, obs_load, obs_run, obs_txd);
    end
  endtask

  task automatic test_timeout();
    int err_cnt;
    int txs_cnt;
    int first_err;
    send_packet(32'h0BADF00D, 32'h13572468, 8'h02, '0, 1'b0, int'(TO) - 8);
    model_packet(32'h0BADF00D, 32'h13572468, 8'h02, '0);
    checks++;
    if (obs_gap_err != 0 || obs_load !== 8'h04 || obs_txd !== 8'h06) begin
      errors++;
      $display("FAIL slow_packet: got gap_err=%0d load=%h data=%h want 0/04/06",
               obs_gap_err, obs_load, obs_txd);
    end
    for (int i = 0; i < 5; i++) drive_byte(8'(8'h30 + i));
    err_cnt   = 0;
    txs_cnt   = 0;
    first_err = -1;
    for (int i = 1; i <= int'(TO) + 16; i++) begin
      @(negedge clk);
      if (o_err_tick) begin
        err_cnt++;
        if (first_err < 0) first_err = i;
      end
      if (o_tx_start) txs_cnt++;
    end
    checks++;
    if (err_cnt != 1 || txs_cnt != 0) begin
      errors++;
      $display("FAIL timeout_err: got err=%0d txs=%0d want 1/0", err_cnt, txs_cnt);
    end
    checks++;
    if (first_err < int'(TO) - 2 || first_err > int'(TO) + 2) begin
      errors++;
      $display("FAIL timeout_time: got %0d want %0d +/-2", first_err, TO);
    end
    send_packet(32'hA1B2C3D4, 32'h55667788, 8'h01, '0, 1'b0, 0);
    model_packet(32'hA1B2C3D4, 32'h55667788, 8'h01, '0);
    checks++;
    if (obs_load !== 8'h02 || obs_txd !== 8'h06 || obs_op !== 32'hA1B2C3D4 || obs_fp !== 32'h55667788) begin
      errors++;
      $display("FAIL after_timeout: got load=%h data=%h op=%h fp=%h want 02/06/a1b2c3d4/55667788",
               obs_load, obs_txd, obs_op, obs_fp);
    end
  endtask

  task automatic test_nak();
    logic [7:0] ctls [3];
    ctls[0] = 8'hC0;
    ctls[1] = 8'h4A;
    ctls[2] = 8'h8A;
    for (int i = 0; i < 3; i++) begin
      send_packet(32'h11111111, 32'h22222222, ctls[i], '0, 1'b0, 0);
      model_packet(32'h11111111, 32'h22222222, ctls[i], '0);
      checks++;
      if ({obs_load, obs_start, obs_stop} !== '0 || obs_txd !== 8'h15 || obs_txs !== 1'b1) begin
        errors++;
        $display("FAIL nak_%h: got strobes=%h start=%b data=%h want 0/1/15",
                 ctls[i], {obs_load, obs_start, obs_stop}, obs_txs, obs_txd);
      end
    end
  endtask

  task automatic test_done_collision();
    send_packet(32'h0F0F0F0F, 32'hF0F0F0F0, 8'h43, 8'h08, 1'b0, 0);
    model_packet(32'h0F0F0F0F, 32'hF0F0F0F0, 8'h43, 8'h08);
    checks++;
    if (obs_run[3] !== 1'b1 || obs_txd !== 8'h06) begin
      errors++;
      $display("FAIL set_wins: got run=%h data=%h want bit3 set, 06", obs_run, obs_txd);
    end
    @(negedge clk);
    done = 8'h28;
    @(negedge clk);
    done  = '0;
    m_run = m_run & ~8'h28;
    checks++;
    if (o_run !== m_run || o_run[3] !== 1'b0) begin
      errors++;
      $display("FAIL done_clear: got %h want %h", o_run, m_run);
    end
  endtask

  task automatic test_back_to_back();
    send_packet(32'h76543210, 32'hFEDCBA98, 8'h06, '0, 1'b1, 0);
    model_packet(32'h76543210, 32'hFEDCBA98, 8'h06, '0);
    checks++;
    if (obs_err !== 1'b1 || obs_txd2 !== obs_txd || obs_txd !== exp_txd) begin
      errors++;
      $display("FAIL wait_drop: got err=%b data=%h held=%h want 1/%h", obs_err, obs_txd, obs_txd2, exp_txd);
    end
    send_packet(32'h02468ACE, 32'h13579BDF, 8'h07, '0, 1'b0, 0);
    model_packet(32'h02468ACE, 32'h13579BDF, 8'h07, '0);
    checks++;
    if (obs_load !== exp_load || obs_txd !== exp_txd || obs_op !== 32'h02468ACE) begin
      errors++;
      $display("FAIL after_drop: got load=%h data=%h op=%h want %h/%h/02468ace",
               obs_load, obs_txd, obs_op, exp_load, exp_txd);
    end
  endtask

  task automatic test_random();
    logic [31:0]   op, fp;
    logic [7:0]    ctl;
    logic [CH-1:0] dmask;
    for (int n = 0; n < 24; n++) begin
      op    = $urandom;
      fp    = $urandom;
      ctl   = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 9))};
      dmask = ($urandom_range(0, 2) == 0) ? CH'($urandom) : '0;
      send_packet(op, fp, ctl, dmask, 1'b0, 0);
      model_packet(op, fp, ctl, dmask);
      checks++;
      if (obs_load !== exp_load || obs_start !== exp_start || obs_stop !== exp_stop ||
          obs_txd !== exp_txd || obs_run !== m_run || obs_op !== m_op || obs_fp !== m_fp) begin
        errors++;
        $display("FAIL rand_%0d ctl=%h: got l=%h s=%h p=%h d=%h r=%h op=%h fp=%h want l=%h s=%h p=%h d=%h r=%h op=%h fp=%h",
                 n, ctl, obs_load, obs_start, obs_stop, obs_txd, obs_run, obs_op, obs_fp,
                 exp_load, exp_start, exp_stop, exp_txd, m_run, m_op, m_fp);
      end
      if ($urandom_range(0, 3) == 0) begin
        dmask = CH'($urandom);
        @(negedge clk);
        done = dmask;
        @(negedge clk);
        done  = '0;
        m_run = m_run & ~dmask;
        checks++;
        if (o_run !== m_run) begin
          errors++;
          $display("FAIL rand_done_%0d: got %h want %h", n, o_run, m_run);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int txs_cnt;
    for (int i = 0; i < 4; i++) drive_byte(8'(8'hE0 + i));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h want 0", all_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    txs_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_tx_start || o_err_tick) txs_cnt++;
    end
    checks++;
    if (txs_cnt != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: got %0d reply/err pulses want 0", txs_cnt);
    end
    send_packet(32'hCAFEBABE, 32'h0DDBA11F, 8'h45, '0, 1'b0, 0);
    model_packet(32'hCAFEBABE, 32'h0DDBA11F, 8'h45, '0);
    checks++;
    if (obs_load !== 8'h20 || obs_start !== 8'h20 || obs_run !== 8'h20 || obs_txd !== 8'h06 ||
        obs_op !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL mid_reset_next: got l=%h s=%h r=%h d=%h op=%h want 20/20/20/06/cafebabe",
               obs_load, obs_start, obs_run, obs_txd, obs_op);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    data    = '0;
    rx_tick = 1'b0;
    done    = '0;
    tx_done = 1'b0;
    model_reset();
    test_reset();
    test_load_start();
    test_reject_running();
    test_timeout();
    test_nak();
    test_done_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
